led_fader: RTL and testbench
============================

LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz; it is informational and used only to derive STEP_DIV.
REQ-002 SHALL have parameter STEP_DIV, default CLK_FREQ/25600, sys_clk cycles per fade step; legal range 1..2^24.
REQ-003 SHALL have port sys_clk  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port led_in  input  4  on/off pattern from the upstream LED pattern generator, synchronous to sys_clk.
REQ-006 SHALL have port bright  input  8  on-level duty, 0..255, sampled every cycle.
REQ-007 SHALL have port fade_en  input  1  1 = ramp duty gradually, 0 = jump duty immediately.
REQ-008 SHALL have port led_pwm  output  4  registered PWM drive per LED, 1 = lit.
REQ-009 SHALL have port busy  output  1  registered; 1 while any duty differs from its target.

Function
REQ-010 SHALL register led_in into led_q every cycle; target[i] = led_q[i] ? bright : 0.
REQ-011 SHALL run an 8-bit free-running pwm_cnt, incrementing every cycle and wrapping 255->0 (period 256 cycles).
REQ-012 SHALL run a 24-bit prescaler counting 0..STEP_DIV-1 and wrapping; step_tick = 1 for exactly the cycle prescaler == STEP_DIV-1 (STEP_DIV=1 -> tick every cycle).
REQ-013 SHALL keep an 8-bit duty[i] per LED, each with its own state: IDLE (duty==target), RISE (duty<target), FALL (duty>target), derived from the registered comparison each cycle.
REQ-014 With fade_en=1, SHALL on step_tick change duty[i] by +1 in RISE, by -1 in FALL, and not at all in IDLE; duty SHALL NOT change between ticks.
REQ-015 With fade_en=0, SHALL load duty[i] <= target[i] on every cycle regardless of step_tick.
REQ-016 Duty SHALL never overshoot the target, wrap past 0 or 255, or step by more than 1 per tick.
REQ-017 When the target changes mid-ramp, SHALL re-evaluate direction on the next cycle and continue stepping from the current duty; the prescaler SHALL NOT be restarted.
REQ-018 When bright changes while an LED is on, SHALL fade duty to the new level at the same step rate.
REQ-019 SHALL register led_pwm[i] <= (pwm_cnt < duty[i]): duty 0 gives constant 0, duty 255 gives high for 255 of every 256 cycles.
REQ-020 SHALL register busy <= OR over i of (duty[i] != target[i]).
REQ-021 Latency: a led_in edge SHALL reach target after 1 cycle; with fade_en=0, duty updates 1 cycle after that and led_pwm 1 cycle after duty (3 cycles total).
REQ-022 When fade_en toggles 1->0 mid-ramp, duty SHALL snap to target on the next cycle; when it toggles 0->1, ramping SHALL start at the next step_tick.

Reset
REQ-023 While sys_rst_n=0, SHALL asynchronously clear led_q, pwm_cnt, prescaler, all duty[i], led_pwm=4'b0000 and busy=0.
REQ-024 After reset deassertion, SHALL resume normal operation on the first rising edge; a reset asserted mid-ramp SHALL discard all ramp progress.

Verification
REQ-025 With STEP_DIV=1, fade_en=0, bright=128, led_in 0->4'b0001: expect led_pwm[0] high for exactly 128 of every 256 cycles from the 3rd cycle; other bits stay 0; busy stays 0 after settling.
REQ-026 With STEP_DIV=4, fade_en=1, bright=8, led_in 0->4'b1000: expect duty[3] to reach 1..8 on successive ticks every 4 cycles; busy=1 throughout and falls to 0 the cycle after duty[3]==8.
REQ-027 Same setup, led_in returns to 0 when duty[3]==5: expect duty[3] to go 5->4->...->0 with no overshoot; busy clears afterwards.
REQ-028 With fade_en=1 mid-ramp at duty=3 and target=8, set fade_en=0: expect duty=8 on the next cycle and busy=0 on the one after.
REQ-029 With a ramp in progress, pulse sys_rst_n low asynchronously for less than one clock period: expect led_pwm=0, busy=0 and all duty=0 immediately; after release, ramping restarts from 0.
REQ-030 With bright=255, fade_en=0, led_in=4'b1111: expect all led_pwm bits low only when pwm_cnt==255 (1 cycle of 256); with bright=0, all led_pwm bits stay 0.

Source files
------------

// File: rtl/led_fader.sv
// led_fader: per-LED PWM driver with optional linear duty ramping.
//
// Each of the four LEDs has an 8-bit duty that either jumps straight to its
// target (fade_en=0) or walks toward it one count per prescaler tick
// (fade_en=1). A shared free-running 8-bit counter turns each duty into a
// 256-cycle PWM waveform.
//
// Per-LED ramp direction (decoded every cycle from registered duty vs. target):
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | duty equals target; duty holds
//   ST_RISE | duty below target; +1 on each step_tick while fading
//   ST_FALL | duty above target; -1 on each step_tick while fading
//
// Because the direction is re-decoded from the live duty every cycle, a
// target change mid-ramp simply redirects the walk from wherever duty is.
// The walk also stops exactly on the target, so duty can never overshoot it
// or wrap past 0 or 255.
module led_fader #(
    parameter int CLK_FREQ = 50000000,
    parameter int STEP_DIV = CLK_FREQ / 25600
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] led_in,
    input  logic [7:0] bright,
    input  logic       fade_en,
    output logic [3:0] led_pwm,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2
    } dir_t;

    // The prescaler wraps after this value. STEP_DIV may be as large as
    // 2^24, so the terminal count still fits in 24 bits.
    localparam logic [23:0] PRESC_LAST = 24'(STEP_DIV - 1);

    logic [3:0]      led_q,     led_d;
    logic [7:0]      pwm_cnt_q, pwm_cnt_d;
    logic [23:0]     presc_q,   presc_d;
    logic [3:0][7:0] duty_q,    duty_d;
    logic [3:0]      led_pwm_q, led_pwm_d;
    logic            busy_q,    busy_d;

    logic            step_tick;
    logic [3:0][7:0] target;
    dir_t            dir [4];

    // Timebase: free-running PWM counter and fade-step prescaler.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        step_tick = (presc_q == PRESC_LAST);
        presc_d   = presc_q + 24'd1;
        if (step_tick) begin
            presc_d = '0;
        end
    end

    // Target selection and per-LED direction decode.
    always_comb begin
        led_d  = led_in;
        target = '0;
        for (int i = 0; i < 4; i++) begin
            dir[i] = ST_IDLE;
        end
        for (int i = 0; i < 4; i++) begin
            target[i] = led_q[i] ? bright : 8'd0;
            if (duty_q[i] < target[i]) begin
                dir[i] = ST_RISE;
            end else if (duty_q[i] > target[i]) begin
                dir[i] = ST_FALL;
            end else begin
                dir[i] = ST_IDLE;
            end
        end
    end

    // Duty update, PWM compare and busy flag.
    always_comb begin
        duty_d    = duty_q;
        led_pwm_d = '0;
        busy_d    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            led_pwm_d[i] = (pwm_cnt_q < duty_q[i]);
            if (dir[i] != ST_IDLE) begin
                busy_d = 1'b1;
            end
            if (!fade_en) begin
                // Immediate mode ignores the prescaler entirely.
                duty_d[i] = target[i];
            end else if (step_tick) begin
                case (dir[i])
                    ST_RISE: duty_d[i] = duty_q[i] + 8'd1;
                    ST_FALL: duty_d[i] = duty_q[i] - 8'd1;
                    default: duty_d[i] = duty_q[i];
                endcase
            end
        end
    end

    // State registers; reset discards any ramp in progress.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            led_q     <= '0;
            pwm_cnt_q <= '0;
            presc_q   <= '0;
            duty_q    <= '0;
            led_pwm_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            led_q     <= led_d;
            pwm_cnt_q <= pwm_cnt_d;
            presc_q   <= presc_d;
            duty_q    <= duty_d;
            led_pwm_q <= led_pwm_d;
            busy_q    <= busy_d;
        end
    end

    assign led_pwm = led_pwm_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader: two instances (STEP_DIV=4 and STEP_DIV=1) share the
// stimulus and are compared every cycle against a cycle-level arithmetic
// model, plus directed scenarios with hand-derived expectations.
module tb_led_fader;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [3:0] led_in;
    logic [7:0] bright;
    logic       fade_en;
    logic [3:0] pwm4, pwm1;
    logic       busy4, busy1;

    int checks = 0;
    int failures = 0;

    led_fader #(.CLK_FREQ(50000000), .STEP_DIV(4)) u_dut4 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .led_in    (led_in),
        .bright    (bright),
        .fade_en   (fade_en),
        .led_pwm   (pwm4),
        .busy      (busy4)
    );

    led_fader #(.CLK_FREQ(50000000), .STEP_DIV(1)) u_dut1 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .led_in    (led_in),
        .bright    (bright),
        .fade_en   (fade_en),
        .led_pwm   (pwm1),
        .busy      (busy1)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference model: index 0 mirrors STEP_DIV=4, index 1 STEP_DIV=1.
    int         m_duty [2][4];
    int         m_presc [2];
    int         m_cnt = 0;
    logic [3:0] m_led = '0;
    logic [3:0] m_pwm [2];
    logic       m_busy [2];

    function automatic int step_div(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    always @(posedge sys_clk or negedge sys_rst_n) begin
        int  tgt;
        bit  tick;
        bit  bz;
        if (!sys_rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) m_duty[k][i] = 0;
                m_presc[k] = 0;
                m_pwm[k]   = '0;
                m_busy[k]  = 1'b0;
            end
            m_cnt = 0;
            m_led = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                tick = (m_presc[k] == step_div(k) - 1);
                bz   = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    tgt = m_led[i] ? int'(bright) : 0;
                    m_pwm[k][i] = (m_cnt < m_duty[k][i]);
                    if (m_duty[k][i] != tgt) bz = 1'b1;
                    if (!fade_en) m_duty[k][i] = tgt;
                    else if (tick && m_duty[k][i] < tgt) m_duty[k][i] = m_duty[k][i] + 1;
                    else if (tick && m_duty[k][i] > tgt) m_duty[k][i] = m_duty[k][i] - 1;
                end
                m_busy[k]  = bz;
                m_presc[k] = (m_presc[k] + 1) % step_div(k);
            end
            m_cnt = (m_cnt + 1) % 256;
            m_led = led_in;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic compare_all();
        chk("pwm_sd4",  int'(pwm4),  int'(m_pwm[0]));
        chk("busy_sd4", int'(busy4), int'(m_busy[0]));
        chk("pwm_sd1",  int'(pwm1),  int'(m_pwm[1]));
        chk("busy_sd1", int'(busy1), int'(m_busy[1]));
    endtask

    // Advance to the next falling edge and compare against the model.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            if (sys_rst_n) compare_all();
        end
    endtask

    task automatic settle_off();
        fade_en = 1'b0;
        led_in  = 4'b0000;
        step(4);
    endtask

    int  cnt_a, cnt_b;
    bit  found, started;

    initial begin
        sys_rst_n = 1'b0;
        led_in    = 4'b0000;
        bright    = 8'd0;
        fade_en   = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_pwm4",  int'(pwm4),  0);
        chk("rst_busy4", int'(busy4), 0);
        chk("rst_pwm1",  int'(pwm1),  0);
        chk("rst_busy1", int'(busy1), 0);
        sys_rst_n = 1'b1;
        step(2);

        // Immediate mode, half brightness on LED0.
        bright = 8'd128;
        led_in = 4'b0001;
        step(3);
        cnt_a = 0;
        for (int n = 0; n < 256; n++) begin
            step(1);
            if (pwm1[0]) cnt_a++;
        end
        chk("half_duty_high", cnt_a, 128);
        chk("half_duty_busy", int'(busy1), 0);

        // Fade up to 8 with STEP_DIV=4.
        settle_off();
        fade_en = 1'b1;
        bright  = 8'd8;
        led_in  = 4'b1000;
        cnt_a   = 0;
        started = 1'b0;
        found   = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            step(1);
            if (busy4) begin
                started = 1'b1;
                cnt_a++;
            end else if (started) begin
                found = 1'b1;
            end
        end
        chk("rampup_done", int'(found), 1);
        chk_range("rampup_busy_len", cnt_a, 29, 32);
        chk("rampup_model_duty", m_duty[0][3], 8);

        // Fade up, reverse at duty 5, fall back to 0.
        settle_off();
        fade_en = 1'b1;
        led_in  = 4'b1000;
        found   = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            step(1);
            if (m_duty[0][3] == 5) found = 1'b1;
        end
        chk("reach_duty5", int'(found), 1);
        led_in = 4'b0000;
        found  = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            step(1);
            if (!busy4) found = 1'b1;
        end
        chk("falldown_done", int'(found), 1);
        chk("falldown_model_duty", m_duty[0][3], 0);
        chk("falldown_pwm", int'(pwm4), 0);

        // fade_en dropped mid-ramp snaps to target.
        settle_off();
        fade_en = 1'b1;
        led_in  = 4'b1000;
        found   = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            step(1);
            if (m_duty[0][3] == 3) found = 1'b1;
        end
        chk("reach_duty3", int'(found), 1);
        fade_en = 1'b0;
        step(1);
        chk("snap_busy_first", int'(busy4), 1);
        chk("snap_model_duty", m_duty[0][3], 8);
        step(1);
        chk("snap_busy_second", int'(busy4), 0);

        // Short asynchronous reset pulse mid-ramp.
        settle_off();
        fade_en = 1'b1;
        bright  = 8'd200;
        led_in  = 4'b1111;
        step(40);
        chk("pre_pulse_busy", int'(busy4), 1);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("pulse_pwm4",  int'(pwm4),  0);
        chk("pulse_busy4", int'(busy4), 0);
        chk("pulse_pwm1",  int'(pwm1),  0);
        chk("pulse_busy1", int'(busy1), 0);
        chk("pulse_model_duty", m_duty[0][0], 0);
        #1 sys_rst_n = 1'b1;
        step(20);
        chk("restart_duty_sd4", m_duty[0][0], 5);
        chk("restart_duty_sd1", m_duty[1][0], 19);

        // Full and zero brightness.
        fade_en = 1'b0;
        bright  = 8'd255;
        led_in  = 4'b1111;
        step(4);
        cnt_a = 0;
        cnt_b = 0;
        for (int n = 0; n < 256; n++) begin
            step(1);
            if (pwm1 == 4'hF) cnt_a++;
            if (pwm1 == 4'h0) cnt_b++;
        end
        chk("full_high_cycles", cnt_a, 255);
        chk("full_low_cycles", cnt_b, 1);
        bright = 8'd0;
        step(4);
        cnt_a = 0;
        for (int n = 0; n < 256; n++) begin
            step(1);
            if (pwm1 != 4'h0) cnt_a++;
        end
        chk("zero_bright_lit", cnt_a, 0);

        // Randomized traffic, compared every cycle.
        for (int n = 0; n < 3000; n++) begin
            step(1);
            if ($urandom_range(39) == 0) led_in  = 4'($urandom);
            if ($urandom_range(59) == 0) bright  = 8'($urandom);
            if ($urandom_range(99) == 0) fade_en = ~fade_en;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
